// File: rtl/mpeg_stream_feeder_pkg.sv
// Shared types and constants for the MPEG byte-stream feeder.
package mpeg_feeder_pkg;

  localparam int unsigned ADDR_W_DEF = 23;
  localparam int unsigned PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/mpeg_stream_feeder_if.sv
// Memory-read and core-input bus of the feeder; master = feeder, slave = memory/core side.
interface mpeg_stream_feeder_if #(
  parameter int unsigned ADDR_W = mpeg_feeder_pkg::ADDR_W_DEF
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mpeg_prog_full;
  logic [7:0]        mpeg_in;
  logic              mpeg_in_en;
  logic              stream_end;

  modport master (
    output mem_rd_en, mem_addr, mpeg_in, mpeg_in_en, stream_end,
    input  mem_rd_data, mpeg_prog_full
  );

  modport slave (
    input  mem_rd_en, mem_addr, mpeg_in, mpeg_in_en, stream_end,
    output mem_rd_data, mpeg_prog_full
  );
endinterface

// File: rtl/mpeg_stream_feeder_rd_pipe.sv
// Two-stage read pipe: read strobe -> memory stage valid -> registered output byte.
module feeder_rd_pipe #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_empty
);

  logic              r_s1_v;
  logic              r_out_v;
  logic [DATA_W-1:0] r_out_d;

  always_ff @(posedge clk) begin
    if (!srst) begin
      r_s1_v  <= 1'b0;
      r_out_v <= 1'b0;
      r_out_d <= '0;
    end else begin
      r_s1_v  <= i_rd_en;
      r_out_v <= r_s1_v;
      if (r_s1_v) r_out_d <= i_rd_data;
    end
  end

  assign o_data  = r_out_d;
  assign o_valid = r_out_v;
  // Empty once nothing waits behind the output register; a byte on o_valid now is the last one.
  assign o_empty = !r_s1_v;

endmodule

// File: rtl/mpeg_stream_feeder.sv
// Streams a (base, length) byte region from synchronous memory into the core input.
// Optional FEEDER_STATS_EN builds the stall/sent counters; otherwise they read 0.
module mpeg_stream_feeder
  import mpeg_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  mpeg_stream_feeder_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         sent_cnt
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_done;
  logic              w_start_ok;
  logic              w_rd;
  logic              w_pipe_empty;
  logic              w_pipe_valid;
  logic [DATA_W-1:0] w_pipe_data;

  assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
  assign w_rd       = (r_state == STREAM) && !bus.mpeg_prog_full && (r_remaining != '0);

  always_ff @(posedge clk) begin
    if (!srst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == FLUSH) && (w_next == DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (length == '0) ? FLUSH : STREAM;
      STREAM:     if (w_rd && r_remaining == (ADDR_W+1)'(1)) w_next = FLUSH;
      FLUSH:      if (w_pipe_empty) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en  = w_rd;
    bus.mem_addr   = r_addr;
    bus.stream_end = (r_state == DONE);
    busy           = (r_state == STREAM) || (r_state == FLUSH);
    done           = r_done;
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_start_ok) begin
      r_addr      <= base_addr;
      r_remaining <= length;
    end else if (w_rd) begin
      r_addr      <= r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  feeder_rd_pipe #(.DATA_W(DATA_W)) u_pipe (
    .clk       (clk),
    .srst      (srst),
    .i_rd_en   (w_rd),
    .i_rd_data (bus.mem_rd_data),
    .o_data    (w_pipe_data),
    .o_valid   (w_pipe_valid),
    .o_empty   (w_pipe_empty)
  );

  assign bus.mpeg_in    = w_pipe_data;
  assign bus.mpeg_in_en = w_pipe_valid;

`ifdef FEEDER_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_sent_cnt;

  always_ff @(posedge clk) begin
    if (!srst || w_start_ok) begin
      r_stall_cnt <= '0;
      r_sent_cnt  <= '0;
    end else begin
      if (r_state == STREAM && bus.mpeg_prog_full && r_remaining != '0 && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_pipe_valid && r_sent_cnt != '1)
        r_sent_cnt <= r_sent_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign sent_cnt  = r_sent_cnt;
`else
  assign stall_cnt = '0;
  assign sent_cnt  = '0;
`endif

endmodule

// File: tb/tb_mpeg_stream_feeder.sv
// Directed self-checking bench for mpeg_stream_feeder; cycle n=0 is the cycle after the start edge.
module tb_mpeg_stream_feeder;
  import mpeg_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic        start = 1'b0;
  logic [22:0] base_addr = '0;
  logic [23:0] length = '0;
  logic        busy, done;
  logic [31:0] stall_cnt, sent_cnt;

  mpeg_stream_feeder_if #(.ADDR_W(23)) bus ();

  mpeg_stream_feeder #(.ADDR_W(23), .DATA_W(8)) dut (
    .clk       (clk),
    .srst      (srst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: mem[i] = i[7:0], one-cycle read latency; 8'hEE marks cycles without a read.
  always_ff @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
    else               bus.mem_rd_data <= 8'hEE;
  end

  int checks = 0;
  int errors = 0;
  int n, first_en_n, last_en_n, se_n, done_cnt, done_n, busy_cnt, rd_pf, en_pf;
  int pf_lo = 1, pf_hi = 0, sp_n = -100;
  logic [7:0]  q_b[$];
  logic [22:0] q_a[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    #1;
    bus.mpeg_prog_full = (n >= pf_lo) && (n <= pf_hi);
    if (n == sp_n) begin
      start = 1'b1; base_addr = 23'h70; length = 24'd2;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    if (bus.mem_rd_en) begin
      q_a.push_back(bus.mem_addr);
      if (bus.mpeg_prog_full) rd_pf++;
    end
    if (bus.mpeg_in_en) begin
      q_b.push_back(bus.mpeg_in);
      if (first_en_n < 0) first_en_n = n;
      last_en_n = n;
      if (bus.mpeg_prog_full) en_pf++;
    end
    if (bus.stream_end && se_n < 0) se_n = n;
    if (done) begin done_cnt++; done_n = n; end
    if (busy) busy_cnt++;
  endtask

  task automatic do_start(input logic [22:0] b, input logic [23:0] len);
    q_a.delete(); q_b.delete();
    first_en_n = -1; last_en_n = -1; se_n = -1; done_n = -1;
    done_cnt = 0; busy_cnt = 0; rd_pf = 0; en_pf = 0;
    base_addr = b; length = len; start = 1'b1;
    n = -1;
    tick();
  endtask

  task automatic run_to_end(input string tag);
    int budget;
    budget = 0;
    while (!bus.stream_end && budget < 60) begin tick(); budget++; end
    chk({tag, "_end_seen"}, 32'(bus.stream_end), 32'd1);
    tick(); tick();
  endtask

  initial begin
    bus.mpeg_prog_full = 1'b0;
    n = 0;
    repeat (3) tick();
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_in_en", 32'(bus.mpeg_in_en), 32'd0);
    chk("rst_mpeg_in", 32'(bus.mpeg_in), 32'd0);
    chk("rst_send", 32'(bus.stream_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stats", stall_cnt | sent_cnt, 32'd0);
    srst = 1'b1;
    tick();

    // Basic stream: bytes at n=2..5, stream_end and done at n=6.
    do_start(23'h10, 24'd4);
    run_to_end("basic");
    chk("basic_nbytes", 32'(q_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("basic_byte", 32'(q_b[i]), 32'h10 + 32'(i));
    chk("basic_first_en", 32'(first_en_n), 32'd2);
    chk("basic_last_en", 32'(last_en_n), 32'd5);
    chk("basic_se_n", 32'(se_n), 32'd6);
    chk("basic_done_n", 32'(done_n), 32'd6);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_busy_cnt", 32'(busy_cnt), 32'd6);

    // Stall cycles 1..5: reads at 0,6,7,8 -> bytes at 2,8,9,10, stream_end at 11.
    pf_lo = 1; pf_hi = 5;
    do_start(23'h10, 24'd4);
    run_to_end("stall");
    chk("stall_nbytes", 32'(q_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("stall_byte", 32'(q_b[i]), 32'h10 + 32'(i));
    chk("stall_rd_during_pf", 32'(rd_pf), 32'd0);
    chk("stall_inflight_le_depth", 32'(en_pf <= PIPE_DEPTH), 32'd1);
    chk("stall_inflight", 32'(en_pf), 32'd1);
    chk("stall_se_n", 32'(se_n), 32'd11);
    chk("stall_done_cnt", 32'(done_cnt), 32'd1);
`ifdef FEEDER_STATS_EN
    chk("stall_cnt", stall_cnt, 32'd5);
    chk("sent_cnt", sent_cnt, 32'd4);
`else
    chk("stall_cnt_tied", stall_cnt, 32'd0);
    chk("sent_cnt_tied", sent_cnt, 32'd0);
`endif
    pf_lo = 1; pf_hi = 0;

    // Zero length: straight to FLUSH, stream_end and done at n=1.
    do_start(23'h30, 24'd0);
    run_to_end("len0");
    chk("len0_reads", 32'(q_a.size()), 32'd0);
    chk("len0_bytes", 32'(q_b.size()), 32'd0);
    chk("len0_se_n", 32'(se_n), 32'd1);
    chk("len0_done_n", 32'(done_n), 32'd1);
    chk("len0_done_cnt", 32'(done_cnt), 32'd1);

    // Address wrap at 2^23.
    do_start(23'h7FFFFE, 24'd4);
    run_to_end("wrap");
    chk("wrap_nreads", 32'(q_a.size()), 32'd4);
    chk("wrap_a0", 32'(q_a[0]), 32'h7FFFFE);
    chk("wrap_a1", 32'(q_a[1]), 32'h7FFFFF);
    chk("wrap_a2", 32'(q_a[2]), 32'h000000);
    chk("wrap_a3", 32'(q_a[3]), 32'h000001);
    chk("wrap_b0", 32'(q_b[0]), 32'hFE);
    chk("wrap_b3", 32'(q_b[3]), 32'h01);

    // Reset after the third byte (n=4), then a fresh replay.
    do_start(23'h20, 24'd8);
    while (q_b.size() < 3 && n < 20) tick();
    chk("mid_three_bytes", 32'(q_b.size()), 32'd3);
    srst = 1'b0;
    tick();
    chk("mid_rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("mid_rst_in_en", 32'(bus.mpeg_in_en), 32'd0);
    chk("mid_rst_mpeg_in", 32'(bus.mpeg_in), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_send", 32'(bus.stream_end), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    srst = 1'b1;
    repeat (4) tick();
    chk("mid_no_more_bytes", 32'(q_b.size()), 32'd3);
    do_start(23'h40, 24'd3);
    run_to_end("replay");
    chk("replay_nbytes", 32'(q_b.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("replay_byte", 32'(q_b[i]), 32'h40 + 32'(i));
    chk("replay_first_en", 32'(first_en_n), 32'd2);
    chk("replay_se_after_last", 32'(se_n), 32'(last_en_n + 1));

    // start pulsed at n=1 with another region must be ignored.
    sp_n = 1;
    do_start(23'h50, 24'd4);
    run_to_end("ign");
    sp_n = -100;
    chk("ign_nreads", 32'(q_a.size()), 32'd4);
    chk("ign_a0", 32'(q_a[0]), 32'h50);
    chk("ign_a3", 32'(q_a[3]), 32'h53);
    chk("ign_nbytes", 32'(q_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("ign_byte", 32'(q_b[i]), 32'h50 + 32'(i));
    chk("ign_se_n", 32'(se_n), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpeg_stream_feeder.md
Name: mpeg_stream_feeder

Overview:
Synthesizable MPEG byte-stream source that drives the input side of the bhargava core (mpeg_in / mpeg_in_en / stream_end) from a byte-wide synchronous memory. It streams a programmed region (base, length) and honours the core's mpeg_prog_full backpressure. At the end it raises stream_end. This replaces the behavioural file feeder for hardware bring-up and on-chip replay.

Parameters:
ADDR_W, 23, byte-address width of the source memory; 2^23 covers the 5 MB clip.
DATA_W, 8, byte width; fixed at 8, and other values are unsupported.

Ports:
clk  in  1  clock
srst  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a stream when idle or done
base_addr  in  ADDR_W  first byte address, sampled on accepted start
length  in  ADDR_W+1  byte count, sampled on accepted start; 0 is legal
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
mpeg_prog_full  in  1  core programmable-full; stop issuing reads while high
mpeg_in  out  8  byte to core
mpeg_in_en  out  1  byte valid, single-cycle qualifier
stream_end  out  1  level; high after the last byte, held until next start or reset
busy  out  1  high in STREAM and FLUSH
done  out  1  one-cycle pulse on entry to DONE
stall_cnt  out  32  stall-cycle counter (see Optional Feature)
sent_cnt  out  32  bytes-delivered counter (see Optional Feature)

Behaviour:
- Reset (srst=0, at a clk edge), including mid-stream:
  - State returns to IDLE.
  - mem_rd_en, mpeg_in_en, stream_end, busy, done and counters go to 0; mpeg_in goes to 8'h00.
  - In-flight reads are discarded and not presented.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE or DONE with start=1:
  - Latch addr=base_addr and remaining=length.
  - Clear stream_end and go to STREAM.
  - If length==0, go straight to FLUSH instead.
- start is ignored in STREAM and FLUSH.
- STREAM, each cycle:
  - Drive mem_rd_en = !mpeg_prog_full && remaining!=0, with mem_addr=addr.
  - On a read: addr increments modulo 2^ADDR_W (wraps silently) and remaining decrements.
  - Move to FLUSH in the cycle the final read issues (remaining becomes 0).
- Read pipeline latency:
  - Read issued in cycle N returns mem_rd_data in N+1.
  - That byte is registered onto mpeg_in with mpeg_in_en=1 in cycle N+2.
  - Back-to-back reads give one byte per cycle, in address order, with no gaps or duplicates.
- Backpressure:
  - mpeg_prog_full is sampled only for read issue.
  - Bytes already in flight (at most 2) are always delivered.
  - Integration rule: the core's programmable-full threshold leaves at least 2 free entries.
- FLUSH: wait until both pipeline stages are empty (last mpeg_in_en has been emitted), then go to DONE.
- DONE entry:
  - stream_end=1 from the cycle after the last mpeg_in_en, or 2 cycles after start for length 0.
  - done pulses for 1 cycle.
- busy=1 exactly while in STREAM or FLUSH.
- mpeg_in holds its last value when mpeg_in_en=0.

Optional Feature:
FEEDER_STATS_EN.
- Defined:
  - stall_cnt increments each STREAM cycle with mpeg_prog_full=1 and remaining!=0.
  - sent_cnt increments on each mpeg_in_en.
  - Both saturate at 32'hFFFF_FFFF and clear on accepted start.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package mpeg_feeder_pkg holds:
  - the state enum (IDLE, STREAM, FLUSH, DONE);
  - the ADDR_W default;
  - the PIPE_DEPTH=2 constant, used in the integration assertion.
- Sub-module feeder_rd_pipe: a 2-stage valid/data shift pipe (rd_en -> mem stage -> output register) with a flush on reset. It exposes an empty flag for FLUSH.

Test Plan:
- Reset, then start with base=0x10 and length=4 over memory mem[i]=i[7:0], prog_full=0 → mpeg_in_en high for 4 consecutive cycles with bytes 10,11,12,13. First byte appears 3 cycles after the start edge; stream_end rises the next cycle; one done pulse.
- Same start with prog_full forced high for cycles 5–9 → no reads during the stall, at most 2 bytes emitted after prog_full rises, output sequence still 10..13 with no duplicates. With FEEDER_STATS_EN: stall_cnt is non-zero and sent_cnt=4.
- length=0 → no mem_rd_en and no mpeg_in_en; stream_end=1 and done pulse 2 cycles after start.
- base=2^ADDR_W-2, length=4 → mem_addr sequence 7FFFFE, 7FFFFF, 000000, 000001.
- Assert srst=0 mid-stream after 3 bytes → all outputs 0 on the next edge, no further mpeg_in_en. A new start then replays from the new base with stream_end low until completion.
- start pulsed during STREAM → ignored; byte count and addresses unchanged.
